// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin two-requester APB master with registered bus and response outputs.
// Optional macro APB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYCLES cycles without PREADY.
module apb_master_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic                  req0_write,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp0_err,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic                  req1_write,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  rsp1_err,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state;
  logic last_grant, owner, grant, expire, done, err_c;
  logic [DATA_WIDTH-1:0] rdata_c;
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end
  // Both valid: alternate away from the previous winner.
  assign grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign req0_ready = state == IDLE && req0_valid && !grant;
  assign req1_ready = state == IDLE && req1_valid && grant;
`ifdef APB_TIMEOUT_EN
  logic [7:0] cnt;
  assign expire = !PREADY && cnt == 8'(TIMEOUT_CYCLES - 1);
`else
  assign expire = 1'b0;
`endif
  assign done    = PREADY || expire;
  assign rdata_c = (PWRITE || expire) ? '0 : PRDATA;
  assign err_c   = PSLVERR || expire;
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
      rsp1_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: if (req0_ready || req1_ready) begin
          PADDR      <= grant ? req1_addr : req0_addr;
          PWRITE     <= grant ? req1_write : req0_write;
          PWDATA     <= grant ? req1_wdata : req0_wdata;
          owner      <= grant;
          last_grant <= grant;
          PSEL       <= 1'b1;
          state      <= SETUP;
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          cnt     <= '0;
`endif
        end
        ACCESS: if (done) begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          state   <= RESP;
          if (owner) begin
            rsp1_valid <= 1'b1;
            rsp1_rdata <= rdata_c;
            rsp1_err   <= err_c;
          end else begin
            rsp0_valid <= 1'b1;
            rsp0_rdata <= rdata_c;
            rsp0_err   <= err_c;
          end
        end
`ifdef APB_TIMEOUT_EN
        else cnt <= cnt + 8'd1;
`endif
        RESP: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed tests plus a cycle-age reference model compared every cycle.
module tb_apb_master_arbiter;
  localparam int AW = 32, DW = 32, TMO = 16;
  logic PCLK = 0, PRESETn = 0;
  logic req0_valid = 0, req0_write = 0, req1_valid = 0, req1_write = 0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata, PWDATA;
  logic [AW-1:0] PADDR;
  logic PWRITE, PSEL, PENABLE;
  logic [DW-1:0] PRDATA = '0;
  logic PREADY = 0, PSLVERR = 0;
  int n_pass = 0, n_total = 0;
  int waits = 0, wcnt = 0, n_en, n_r0, n_r1;
  bit hold = 0;
  logic [DW-1:0] slv_rdata = '0;
  logic slv_err = 0;
  int acc_cyc[$];
  bit acc_g[$];
  logic [AW-1:0] pa[$];
  bit m_busy, m_resp, m_last, m_own, m_pw;
  int m_age;
  logic [AW-1:0] m_pa;
  logic [DW-1:0] m_pd;
  logic [DW-1:0] m_rd[2];
  bit m_er[2];

  always #5 PCLK = ~PCLK;

  apb_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_write(req0_write), .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid),
    .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_write(req1_write), .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid),
    .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge PCLK);
    #2;
  endtask

  function automatic bit pick();
    return (req0_valid && req1_valid) ? !m_last : req1_valid;
  endfunction

  // Slave: PREADY rises after `waits` ACCESS cycles unless held off.
  always @(posedge PCLK) begin
    #1;
    wcnt = (PSEL && PENABLE) ? wcnt + 1 : 0;
    PREADY = !hold && wcnt > waits;
    PSLVERR = slv_err;
    PRDATA = slv_rdata;
  end

  // Model: a transfer is tracked by its age in cycles since acceptance.
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      m_busy = 0; m_resp = 0; m_last = 1; m_own = 0; m_pw = 0; m_age = 0;
      m_pa = '0; m_pd = '0; m_rd = '{'0, '0}; m_er = '{0, 0};
    end else if (m_resp) m_resp = 0;
    else if (m_busy) begin
      bit tmo;
      tmo = 0;
`ifdef APB_TIMEOUT_EN
      tmo = !PREADY && (m_age - 1) == TMO;
`endif
      if (m_age >= 2 && (PREADY || tmo)) begin
        m_rd[m_own] = (m_pw || tmo) ? '0 : PRDATA;
        m_er[m_own] = tmo || PSLVERR;
        m_busy = 0;
        m_resp = 1;
      end else m_age++;
    end else if (req0_valid || req1_valid) begin
      m_own = pick();
      m_last = m_own;
      m_pa = m_own ? req1_addr : req0_addr;
      m_pw = m_own ? req1_write : req0_write;
      m_pd = m_own ? req1_wdata : req0_wdata;
      m_busy = 1;
      m_age = 1;
    end
  end

  always @(negedge PCLK) begin
    bit g;
    g = pick();
    check("req0_ready", req0_ready, !m_busy && !m_resp && req0_valid && !g);
    check("req1_ready", req1_ready, !m_busy && !m_resp && req1_valid && g);
    check("PSEL", PSEL, m_busy);
    check("PENABLE", PENABLE, m_busy && m_age >= 2);
    check("PADDR", PADDR, m_pa);
    check("PWRITE", PWRITE, m_pw);
    check("PWDATA", PWDATA, m_pd);
    check("rsp0_valid", rsp0_valid, m_resp && !m_own);
    check("rsp1_valid", rsp1_valid, m_resp && m_own);
    check("rsp0_rdata", rsp0_rdata, m_rd[0]);
    check("rsp1_rdata", rsp1_rdata, m_rd[1]);
    check("rsp0_err", rsp0_err, m_er[0]);
    check("rsp1_err", rsp1_err, m_er[1]);
  end

  initial begin
    tick(2);
    check("rst PSEL", PSEL, 0);
    check("rst PENABLE", PENABLE, 0);
    check("rst PADDR", PADDR, 0);
    check("rst rsp0_valid", rsp0_valid, 0);
    check("rst rsp1_rdata", rsp1_rdata, 0);
    PRESETn = 1;
    tick();
    // zero-wait write from requester 0
    req0_addr = 32'h10; req0_write = 1; req0_wdata = 32'hDEADBEEF; req0_valid = 1;
    #1;
    check("t1 req0_ready", req0_ready, 1);
    check("t1 req1_ready", req1_ready, 0);
    tick();
    req0_valid = 0;
    check("t1 setup PSEL", PSEL, 1);
    check("t1 setup PENABLE", PENABLE, 0);
    check("t1 setup PADDR", PADDR, 32'h10);
    check("t1 setup PWRITE", PWRITE, 1);
    check("t1 setup PWDATA", PWDATA, 32'hDEADBEEF);
    tick();
    check("t1 access PENABLE", PENABLE, 1);
    tick();
    check("t1 rsp0_valid", rsp0_valid, 1);
    check("t1 rsp0_err", rsp0_err, 0);
    check("t1 rsp0_rdata", rsp0_rdata, 0);
    check("t1 resp PSEL", PSEL, 0);
    tick();
    check("t1 rsp0_valid drop", rsp0_valid, 0);
    // read from requester 1 with 3 wait states
    req1_addr = 32'h20; req1_write = 0; req1_valid = 1; waits = 3; slv_rdata = 32'h12345678;
    #1;
    check("t2 req1_ready", req1_ready, 1);
    n_en = 0; n_r0 = 0; n_r1 = 0;
    tick();
    req1_valid = 0;
    for (int i = 0; i < 12; i++) begin
      n_en += PENABLE; n_r0 += rsp0_valid; n_r1 += rsp1_valid;
      tick();
    end
    check("t2 penable cycles", n_en, 4);
    check("t2 rsp1 count", n_r1, 1);
    check("t2 rsp0 count", n_r0, 0);
    check("t2 rsp1_rdata", rsp1_rdata, 32'h12345678);
    // both requesters held valid after reset
    PRESETn = 0;
    tick();
    PRESETn = 1;
    tick();
    req0_addr = 32'h100; req0_write = 0; req1_addr = 32'h200; req1_write = 0; waits = 0;
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (req0_ready || req1_ready) begin acc_cyc.push_back(i); acc_g.push_back(req1_ready); end
      if (PSEL && !PENABLE) pa.push_back(PADDR);
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    check("t3 accepts", acc_cyc.size(), 4);
    check("t3 setups", pa.size(), 4);
    for (int k = 0; k < 4 && k < acc_cyc.size() && k < pa.size(); k++) begin
      check("t3 accept cycle", acc_cyc[k], 4 * k);
      check("t3 grant", acc_g[k], k % 2);
      check("t3 PADDR", pa[k], (k % 2) ? 32'h200 : 32'h100);
    end
    tick(3);
    // slave error on a read, then a clean read
    req0_addr = 32'h30; req0_write = 0; waits = 1; slv_rdata = 32'hCAFEF00D; slv_err = 1;
    req0_valid = 1;
    tick();
    req0_valid = 0;
    tick(6);
    check("t4 rsp0_err", rsp0_err, 1);
    check("t4 rsp0_rdata", rsp0_rdata, 32'hCAFEF00D);
    slv_err = 0; slv_rdata = 32'h11; req0_addr = 32'h34; waits = 0; req0_valid = 1;
    tick();
    req0_valid = 0;
    tick(5);
    check("t4 next rsp0_err", rsp0_err, 0);
    check("t4 next rsp0_rdata", rsp0_rdata, 32'h11);
    // reset mid-ACCESS
    req0_addr = 32'h40; req0_write = 1; req0_wdata = 32'h55; waits = 5; req0_valid = 1;
    tick();
    req0_valid = 0;
    tick();
    check("t5 in access", PENABLE, 1);
    PRESETn = 0;
    #1;
    check("t5 rst PSEL", PSEL, 0);
    check("t5 rst PENABLE", PENABLE, 0);
    tick();
    PRESETn = 1;
    n_r0 = 0;
    for (int i = 0; i < 3; i++) begin n_r0 += rsp0_valid; tick(); end
    check("t5 no rsp0", n_r0, 0);
    waits = 0; req0_addr = 32'h44; req1_addr = 32'h48; req0_valid = 1; req1_valid = 1;
    #1;
    check("t5 req0 wins", req0_ready, 1);
    check("t5 req1 waits", req1_ready, 0);
    tick();
    req0_valid = 0; req1_valid = 0;
    check("t5 PADDR", PADDR, 32'h44);
    tick(4);
    // stalled slave
    hold = 1; req1_addr = 32'h60; req1_write = 0; slv_rdata = 32'hABCD; req1_valid = 1;
    tick();
    req1_valid = 0;
`ifdef APB_TIMEOUT_EN
    n_en = 0; n_r1 = 0;
    for (int i = 0; i < 30; i++) begin n_en += PENABLE; n_r1 += rsp1_valid; tick(); end
    check("t6 access cycles", n_en, TMO);
    check("t6 rsp1 count", n_r1, 1);
    check("t6 rsp1_err", rsp1_err, 1);
    check("t6 rsp1_rdata", rsp1_rdata, 0);
    check("t6 PSEL", PSEL, 0);
    hold = 0;
`else
    tick(40);
    check("t6 PSEL held", PSEL, 1);
    check("t6 PENABLE held", PENABLE, 1);
    hold = 0;
    n_r1 = 0;
    for (int i = 0; i < 6; i++) begin n_r1 += rsp1_valid; tick(); end
    check("t6 rsp1 count", n_r1, 1);
    check("t6 rsp1_rdata", rsp1_rdata, 32'hABCD);
`endif
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
Two-port APB master that shares one APB bus between two independent requesters, such as the AXI4-Lite read and write channel front ends.
- Accepts one transaction at a time from a simple valid/ready request interface.
- Round-robin arbitration between the two requesters.
- Sequences the APB SETUP and ACCESS phases and waits on PREADY.
- Returns read data and error status to the winning requester as a one-cycle response pulse.

Parameters:
ADDR_WIDTH, 32, width of request address and PADDR
DATA_WIDTH, 32, width of write/read data and PWDATA/PRDATA
TIMEOUT_CYCLES, 16, max ACCESS cycles before abort (only with APB_TIMEOUT_EN); legal range 1..255

Ports:
PCLK  in  1  APB clock, all logic on rising edge
PRESETn  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has a transaction
req0_ready  out  1  requester 0 transaction accepted this cycle
req0_addr  in  ADDR_WIDTH  requester 0 address
req0_write  in  1  1=write, 0=read
req0_wdata  in  DATA_WIDTH  requester 0 write data
rsp0_valid  out  1  one-cycle response pulse to requester 0
rsp0_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp0_err  out  1  PSLVERR or timeout for the completed transfer
req1_valid, req1_ready, req1_addr, req1_write, req1_wdata, rsp1_valid, rsp1_rdata, rsp1_err  same as port 0, for requester 1
PADDR  out  ADDR_WIDTH  APB address
PWRITE  out  1  APB direction
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWDATA  out  DATA_WIDTH  APB write data
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Reset is PRESETn, asynchronous, active-low. While low:
  - state=IDLE.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA all 0.
  - rsp*_valid, rsp*_rdata, rsp*_err all 0.
  - last_grant=1, so requester 0 wins first after reset.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - grant = requester whose valid is high.
  - If both are valid, grant the one not equal to last_grant.
  - reqN_ready is combinational: (state==IDLE) && reqN_valid && grant==N. Never both high.
  - On accept: register addr/write/wdata onto PADDR/PWRITE/PWDATA, set owner=N, last_grant=N, go SETUP.
  - No request: stay IDLE with PSEL=0.
- SETUP: PSEL=1, PENABLE=0, for exactly one cycle, then ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1. PADDR, PWRITE and PWDATA are held stable.
  - Each cycle PREADY=0: remain in ACCESS (wait states unbounded unless APB_TIMEOUT_EN).
  - PREADY=1: capture rdata = PWRITE ? 0 : PRDATA, and err = PSLVERR. Drop PSEL/PENABLE next cycle, go RESP.
- RESP:
  - rsp<owner>_valid=1 for one cycle, with rdata/err.
  - The other port's rsp_valid stays 0.
  - Go IDLE.
  - rdata/err hold their values until the next response.
- Latency:
  - Accept at cycle N; SETUP at N+1; ACCESS at N+2.
  - With zero wait states, PREADY is high at N+2 and rsp_valid is at N+3.
  - Each wait state adds one cycle.
  - The next accept is earliest at N+4, so back-to-back transfers take 4 cycles each.
- Requests arriving while busy wait; reqN_ready stays 0 and inputs are not sampled.
- Requester inputs may change after accept without affecting the in-flight transfer.
- PSLVERR is ignored unless PREADY=1 in ACCESS.
- Reset asserted mid-transfer: the bus is abandoned immediately, all outputs go to reset values, and no response is issued.

Optional Feature:
APB_TIMEOUT_EN
- With it: an 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES with PREADY still 0: abort, drop PSEL/PENABLE, go RESP with rdata=0 and err=1.
  - If PREADY=1 in the same cycle the limit is hit, PREADY wins and the transfer completes normally.
- Without it: no counter is present, ACCESS waits indefinitely, and TIMEOUT_CYCLES is unused.

Test Plan:
- Reset, then req0 write addr 0x10 data 0xDEADBEEF, PREADY tied 1 -> req0_ready at cycle N; SETUP at N+1 (PSEL=1, PENABLE=0, PADDR=0x10, PWRITE=1); ACCESS at N+2; rsp0_valid at N+3 with err=0, rdata=0.
- req1 read addr 0x20; slave returns PRDATA=0x12345678 after 3 wait states -> PENABLE high 4 cycles, rsp1_valid once with rdata=0x12345678, rsp0_valid stays 0.
- req0 and req1 held valid continuously for 4 transfers just after reset -> grants alternate 0,1,0,1; each accept 4 cycles apart; PADDR matches the granted requester each time.
- Read with PSLVERR=1 on the PREADY cycle -> rsp_err=1, rdata = PRDATA value; the next transfer reports err=0.
- PRESETn pulsed low during ACCESS of a req0 write -> PSEL/PENABLE drop to 0 at once, no rsp0_valid, next grant goes to req0.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, PREADY held 0 -> abort after 16 ACCESS cycles, rsp_valid with err=1, rdata=0, PSEL=0; without the macro -> PSEL stays high indefinitely.
